// File: rtl/modulo_udc_pkg.sv
// Shared encodings for the modulo up/down counter: direction and boundary-mode values.
package modulo_udc_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/modulo_updown_counter_next_calc.sv
// Combinational next-count calculator: one step up or down within [0, MAX_VAL],
// wrapping or saturating at the boundary, and flagging when the boundary is hit.
module udc_next_calc
  import modulo_udc_pkg::*;
#(
  parameter int                WIDTH   = 32,
  parameter logic [WIDTH-1:0]  MAX_VAL = '1,
  parameter logic [WIDTH-1:0]  STEP    = 1
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             ctrl,
  input  logic             mode,
  output logic [WIDTH-1:0] cnt_nxt,
  output logic             hit
);

  // One extra bit so cnt+STEP and MAX_VAL+1 never truncate at MAX_VAL = 2**WIDTH-1.
  localparam logic [WIDTH:0] MAX_E  = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] MOD_E  = MAX_E + 1'b1;
  localparam logic [WIDTH:0] STEP_E = {1'b0, STEP};

  logic [WIDTH:0] cnt_e;
  logic [WIDTH:0] up_sum;

  assign cnt_e  = {1'b0, cnt};
  assign up_sum = cnt_e + STEP_E;

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    cnt_nxt = cnt;
    hit     = 1'b0;
    unique case (ctrl)
      DIR_UP: begin
        hit = (up_sum > MAX_E);
        if (!hit) begin
          cnt_nxt = WIDTH'(up_sum);
        end else begin
          case (mode)
            MODE_SAT: cnt_nxt = MAX_VAL;
            default:  cnt_nxt = WIDTH'(up_sum - MOD_E);
          endcase
        end
      end
      DIR_DOWN: begin
        hit = (cnt_e < STEP_E);
        if (!hit) begin
          cnt_nxt = WIDTH'(cnt_e - STEP_E);
        end else begin
          case (mode)
            MODE_WRAP: cnt_nxt = WIDTH'(cnt_e + (MOD_E - STEP_E));
            default:   cnt_nxt = '0;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/modulo_updown_counter.sv
// Modulo up/down counter with wrap/saturate, load and terminal-count pulse.
// Define MODULO_UDC_OVF_EN to add the sticky ovf flag with its clr_ovf input.
module modulo_updown_counter
  import modulo_udc_pkg::*;
#(
  parameter int                WIDTH   = 32,
  parameter logic [WIDTH-1:0]  MAX_VAL = '1,
  parameter logic [WIDTH-1:0]  STEP    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ctrl,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MODULO_UDC_OVF_EN
  input  logic             clr_ovf,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic             tc_d, tc_q;
  logic [WIDTH-1:0] step_cnt;
  logic             step_hit;

  udc_next_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .STEP    (STEP)
  ) u_next_calc (
    .cnt     (cnt_q),
    .ctrl    (ctrl),
    .mode    (mode),
    .cnt_nxt (step_cnt),
    .hit     (step_hit)
  );

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (load) begin
      cnt_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      cnt_d = step_cnt;
      tc_d  = step_hit;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;

`ifdef MODULO_UDC_OVF_EN
  logic ovf_d, ovf_q;

  // A boundary hit wins over a simultaneous clear.
  always_comb begin
    ovf_d = tc_d | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Self-checking bench: directed counting, vector table, STEP=4 wrap, async reset,
// optional ovf sequence and randomized comparison against an arithmetic model.
module tb_modulo_updown_counter;

  localparam int W    = 4;
  localparam int MAXV = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, ctrl, mode, load, clr_ovf;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt1, cnt4;
  logic         tc1, tc4, ovf1, ovf4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  modulo_updown_counter #(.WIDTH(W), .MAX_VAL(MAXV), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .ctrl(ctrl), .mode(mode), .load(load),
    .load_val(load_val),
`ifdef MODULO_UDC_OVF_EN
    .clr_ovf(clr_ovf), .ovf(ovf1),
`endif
    .cnt(cnt1), .tc(tc1)
  );

  modulo_updown_counter #(.WIDTH(W), .MAX_VAL(MAXV), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .ctrl(ctrl), .mode(mode), .load(load),
    .load_val(load_val),
`ifdef MODULO_UDC_OVF_EN
    .clr_ovf(clr_ovf), .ovf(ovf4),
`endif
    .cnt(cnt4), .tc(tc4)
  );

`ifndef MODULO_UDC_OVF_EN
  assign ovf1 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  typedef struct {
    bit load;
    bit en;
    bit ctrl;
    bit mode;
    int lval;
    int exp_cnt;
    bit exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour from the counting rules, using plain signed integers.
  function automatic void ref_step(input int c, input bit ld, input bit en_i, input bit up,
                                   input bit sat, input int lval, input int maxv, input int stepv,
                                   output int nc, output bit ntc);
    int n;
    nc  = c;
    ntc = 1'b0;
    if (ld) begin
      nc = (lval > maxv) ? maxv : lval;
    end else if (en_i) begin
      n = up ? c + stepv : c - stepv;
      if (n > maxv) begin
        ntc = 1'b1;
        nc  = sat ? maxv : n - (maxv + 1);
      end else if (n < 0) begin
        ntc = 1'b1;
        nc  = sat ? 0 : n + (maxv + 1);
      end else begin
        nc = n;
      end
    end
  endfunction

  task automatic drive(input bit ld, input bit e, input bit c, input bit m, input int lv, input bit clr);
    load     = ld;
    en       = e;
    ctrl     = c;
    mode     = m;
    load_val = W'(lv);
    clr_ovf  = clr;
  endtask

  initial begin
    int m1, m4, n1, n4;
    bit t1, t4, mo1, mo4;

    rst_n = 1'b0;
    drive(0, 0, 1, 0, 0, 0);
    #3;
    check("reset_cnt", 32'(cnt1), 0);
    check("reset_tc", 32'(tc1), 0);
    check("reset_ovf", 32'(ovf1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up count through one wrap.
    drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("up_cnt_%0d", i), 32'(cnt1), (i + 1) % 10);
      check($sformatf("up_tc_%0d", i), 32'(tc1), (i == 9) ? 1 : 0);
    end

    vecs.push_back('{1, 0, 1, 1, 9, 9, 0});
    vecs.push_back('{0, 1, 1, 1, 0, 9, 1});
    vecs.push_back('{0, 1, 1, 1, 0, 9, 1});
    vecs.push_back('{0, 1, 1, 1, 0, 9, 1});
    vecs.push_back('{1, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 0, 1});
    vecs.push_back('{0, 1, 0, 0, 0, 9, 1});
    vecs.push_back('{0, 1, 0, 0, 0, 8, 0});
    vecs.push_back('{0, 0, 1, 0, 0, 8, 0});
    vecs.push_back('{1, 1, 1, 0, 14, 9, 0});
    vecs.push_back('{1, 1, 0, 0, 3, 3, 0});
    vecs.push_back('{0, 1, 1, 1, 0, 4, 0});
    vecs.push_back('{1, 0, 1, 1, 8, 8, 0});
    vecs.push_back('{0, 1, 1, 1, 0, 9, 0});
    vecs.push_back('{0, 1, 1, 1, 0, 9, 1});
    vecs.push_back('{0, 1, 1, 0, 0, 0, 1});
    foreach (vecs[i]) begin
      drive(vecs[i].load, vecs[i].en, vecs[i].ctrl, vecs[i].mode, vecs[i].lval, 0);
      tick();
      check($sformatf("vec_cnt_%0d", i), 32'(cnt1), 32'(vecs[i].exp_cnt));
      check($sformatf("vec_tc_%0d", i), 32'(tc1), 32'(vecs[i].exp_tc));
    end

    // STEP=4 wrap in both directions.
    drive(1, 0, 0, 0, 2, 0);
    tick();
    check("s4_load", 32'(cnt4), 2);
    drive(0, 1, 0, 0, 0, 0);
    tick();
    check("s4_down_cnt", 32'(cnt4), 8);
    check("s4_down_tc", 32'(tc4), 1);
    drive(0, 1, 1, 0, 0, 0);
    tick();
    check("s4_up_cnt", 32'(cnt4), 2);
    check("s4_up_tc", 32'(tc4), 1);

    // Async reset between edges while tc is high, then count from zero.
    drive(1, 0, 1, 0, 9, 0);
    tick();
    drive(0, 1, 1, 0, 0, 0);
    tick();
    check("pre_rst_tc", 32'(tc1), 1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_cnt", 32'(cnt1), 0);
    check("mid_rst_tc", 32'(tc1), 0);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_cnt", 32'(cnt1), 1);
    check("post_rst_tc", 32'(tc1), 0);

`ifdef MODULO_UDC_OVF_EN
    drive(1, 0, 1, 0, 9, 1);
    tick();
    check("ovf_clr0", 32'(ovf1), 0);
    drive(0, 1, 1, 0, 0, 0);
    tick();
    check("ovf_set", 32'(ovf1), 1);
    drive(0, 0, 1, 0, 0, 0);
    tick();
    check("ovf_sticky", 32'(ovf1), 1);
    drive(0, 0, 1, 0, 0, 1);
    tick();
    check("ovf_cleared", 32'(ovf1), 0);
    drive(1, 0, 1, 0, 9, 0);
    tick();
    drive(0, 1, 1, 0, 0, 1);
    tick();
    check("ovf_set_wins", 32'(ovf1), 1);
`endif

    // Randomized run against the reference model, both step sizes.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m1 = 0; m4 = 0; mo1 = 0; mo4 = 0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            1'($urandom), int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
      ref_step(m1, load, en, ctrl, mode, int'(load_val), MAXV, 1, n1, t1);
      ref_step(m4, load, en, ctrl, mode, int'(load_val), MAXV, 4, n4, t4);
`ifdef MODULO_UDC_OVF_EN
      mo1 = t1 | (mo1 & ~clr_ovf);
      mo4 = t4 | (mo4 & ~clr_ovf);
`endif
      m1 = n1;
      m4 = n4;
      tick();
      check($sformatf("rnd_cnt1_%0d", i), 32'(cnt1), 32'(m1));
      check($sformatf("rnd_tc1_%0d", i), 32'(tc1), 32'(t1));
      check($sformatf("rnd_cnt4_%0d", i), 32'(cnt4), 32'(m4));
      check($sformatf("rnd_tc4_%0d", i), 32'(tc4), 32'(t4));
      check($sformatf("rnd_ovf1_%0d", i), 32'(ovf1), 32'(mo1));
      check($sformatf("rnd_ovf4_%0d", i), 32'(ovf4), 32'(mo4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
